// File: rtl/rank_sort_buf.sv
// rtl/rank_sort_buf.sv - DEPTH-entry rank-sorted buffer draining an upstream rank stage.
// Optional RANK_SORT_WRAP_EN: serial-number (wrap-tolerant) rank ordering.
module rank_sort_buf #(
    parameter int RANK_WIDTH = 16,
    parameter int META_WIDTH = 16,
    parameter int L2_DEPTH   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [RANK_WIDTH-1:0] in_rank,
    input  logic [META_WIDTH-1:0] in_meta,
    output logic                  in_remove,
    input  logic                  deq,
    output logic                  valid_out,
    output logic [RANK_WIDTH-1:0] rank_out,
    output logic [META_WIDTH-1:0] meta_out,
    output logic [L2_DEPTH:0]     count,
    output logic                  full
);
    localparam int DEPTH = 1 << L2_DEPTH;

    logic [RANK_WIDTH-1:0] rank_q [DEPTH];
    logic [RANK_WIDTH-1:0] rank_d [DEPTH];
    logic [META_WIDTH-1:0] meta_q [DEPTH];
    logic [META_WIDTH-1:0] meta_d [DEPTH];
    logic [L2_DEPTH:0]     count_q, count_d;

    logic [RANK_WIDTH-1:0] shift_rank [DEPTH];
    logic [META_WIDTH-1:0] shift_meta [DEPTH];
    logic [DEPTH-1:0]      keep;
    logic [L2_DEPTH:0]     remain;
    logic                  deq_fire;
    logic                  enq_fire;

    function automatic logic rank_before(input logic [RANK_WIDTH-1:0] a,
                                         input logic [RANK_WIDTH-1:0] b);
`ifdef RANK_SORT_WRAP_EN
        logic [RANK_WIDTH-1:0] diff;
        diff = a - b;
        return diff[RANK_WIDTH-1];
`else
        return a < b;
`endif
    endfunction

    assign full      = (count_q == (L2_DEPTH+1)'(DEPTH));
    assign count     = count_q;
    assign valid_out = (count_q != '0);
    assign rank_out  = rank_q[0];
    assign meta_out  = meta_q[0];
    assign in_remove = in_valid && !full && !rst;

    always_comb begin
        deq_fire = deq && valid_out;
        enq_fire = in_remove;
        remain   = count_q - (L2_DEPTH+1)'(deq_fire);
        count_d  = count_q;
        keep     = '0;
        for (int j = 0; j < DEPTH; j++) begin
            shift_rank[j] = rank_q[j];
            shift_meta[j] = meta_q[j];
            rank_d[j]     = rank_q[j];
            meta_d[j]     = meta_q[j];
        end

        if (deq_fire) begin
            for (int j = 0; j < DEPTH - 1; j++) begin
                shift_rank[j] = rank_q[j+1];
                shift_meta[j] = meta_q[j+1];
            end
        end

        // Sorted order makes keep a prefix; the new entry lands just past it (after equal ranks).
        for (int j = 0; j < DEPTH; j++) begin
            keep[j] = ((L2_DEPTH+1)'(j) < remain) && !rank_before(in_rank, shift_rank[j]);
        end

        for (int j = 0; j < DEPTH; j++) begin
            rank_d[j] = shift_rank[j];
            meta_d[j] = shift_meta[j];
            if (enq_fire && !keep[j]) begin
                if (j == 0 || keep[(j == 0) ? 0 : j-1]) begin
                    rank_d[j] = in_rank;
                    meta_d[j] = in_meta;
                end else begin
                    rank_d[j] = shift_rank[(j == 0) ? 0 : j-1];
                    meta_d[j] = shift_meta[(j == 0) ? 0 : j-1];
                end
            end
        end

        if (enq_fire && !deq_fire) begin
            count_d = count_q + 1'b1;
        end else if (deq_fire && !enq_fire) begin
            count_d = count_q - 1'b1;
        end

        if (rst) begin
            count_d = '0;
            for (int j = 0; j < DEPTH; j++) begin
                rank_d[j] = '0;
                meta_d[j] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
        for (int j = 0; j < DEPTH; j++) begin
            rank_q[j] <= rank_d[j];
            meta_q[j] <= meta_d[j];
        end
    end
endmodule

// File: tb/tb_rank_sort_buf.sv
// tb/tb_rank_sort_buf.sv - Self-checking bench for rank_sort_buf (vectors, corner sequences, random vs model).
module tb_rank_sort_buf;
    logic        clk = 1'b0;
    logic        rst, in_valid, deq;
    logic [15:0] in_rank, in_meta;
    logic        in_remove, valid_out, full;
    logic [15:0] rank_out, meta_out;
    logic [3:0]  count;

    int pass_cnt = 0;
    int total    = 0;
    logic got_rem;

    typedef struct { logic [15:0] rank; logic [15:0] meta; } ent_t;
    ent_t model[$];

    typedef struct {
        logic        rst, v, d;
        logic [15:0] rank, meta;
        logic        e_rem, e_valid, chk_data;
        logic [15:0] e_rank, e_meta;
        logic [3:0]  e_count;
    } vec_t;
    vec_t vecs[13];

    rank_sort_buf dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_rank(in_rank), .in_meta(in_meta),
        .in_remove(in_remove), .deq(deq), .valid_out(valid_out), .rank_out(rank_out),
        .meta_out(meta_out), .count(count), .full(full)
    );

    always #5 clk = ~clk;

    function automatic bit precedes(input logic [15:0] a, input logic [15:0] b);
`ifdef RANK_SORT_WRAP_EN
        return ((int'(a) - int'(b) + 65536) % 65536) >= 32768;
`else
        return a < b;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Drive one cycle, check in_remove against the model, then advance the model with the edge.
    task automatic step(input logic r, input logic v, input logic [15:0] rk,
                        input logic [15:0] mt, input logic d);
        int idx;
        logic exp_rem;
        rst = r; in_valid = v; in_rank = rk; in_meta = mt; deq = d;
        #1;
        got_rem = in_remove;
        exp_rem = !r && v && (model.size() < 8);
        check("in_remove", got_rem, exp_rem);
        if (r) model.delete();
        else begin
            if (d && model.size() > 0) void'(model.pop_front());
            if (exp_rem) begin
                idx = model.size();
                for (int i = 0; i < model.size(); i++)
                    if (precedes(rk, model[i].rank)) begin idx = i; break; end
                model.insert(idx, '{rank: rk, meta: mt});
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; deq = 1'b0;
    endtask

    task automatic check_model();
        check("count", count, model.size());
        check("full", full, model.size() == 8);
        check("valid_out", valid_out, model.size() != 0);
        if (model.size() != 0) begin
            check("rank_out", rank_out, model[0].rank);
            check("meta_out", meta_out, model[0].meta);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; deq = 1'b0; in_rank = '0; in_meta = '0;
        @(posedge clk); #1;

        vecs[0]  = '{1,0,0,16'd0,16'h0,   0,0,1,16'd0,16'h0,0};
        vecs[1]  = '{0,1,0,16'd5,16'hA,   1,1,1,16'd5,16'hA,1};
        vecs[2]  = '{0,1,0,16'd2,16'hB,   1,1,1,16'd2,16'hB,2};
        vecs[3]  = '{0,1,0,16'd9,16'hC,   1,1,1,16'd2,16'hB,3};
        vecs[4]  = '{0,1,0,16'd2,16'hD,   1,1,1,16'd2,16'hB,4};
        vecs[5]  = '{0,0,1,16'd0,16'h0,   0,1,1,16'd2,16'hD,3};
        vecs[6]  = '{0,0,1,16'd0,16'h0,   0,1,1,16'd5,16'hA,2};
        vecs[7]  = '{0,0,1,16'd0,16'h0,   0,1,1,16'd9,16'hC,1};
        vecs[8]  = '{0,0,1,16'd0,16'h0,   0,0,0,16'd0,16'h0,0};
        vecs[9]  = '{0,0,1,16'd0,16'h0,   0,0,0,16'd0,16'h0,0};
        vecs[10] = '{0,0,1,16'd0,16'h0,   0,0,0,16'd0,16'h0,0};
        vecs[11] = '{0,0,1,16'd0,16'h0,   0,0,0,16'd0,16'h0,0};
        vecs[12] = '{0,1,0,16'd3,16'h7,   1,1,1,16'd3,16'h7,1};

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].v, vecs[i].rank, vecs[i].meta, vecs[i].d);
            check($sformatf("vec%0d_rem", i), got_rem, vecs[i].e_rem);
            check($sformatf("vec%0d_valid", i), valid_out, vecs[i].e_valid);
            check($sformatf("vec%0d_count", i), count, vecs[i].e_count);
            if (vecs[i].chk_data) begin
                check($sformatf("vec%0d_rank", i), rank_out, vecs[i].e_rank);
                check($sformatf("vec%0d_meta", i), meta_out, vecs[i].e_meta);
            end
        end

        // Fill to full, then deq with in_valid while full must not enqueue.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 16'($urandom_range(0, 20)), 16'(i), 0);
            check("fill_rem", got_rem, 1'b1);
        end
        check("full_flag", full, 1'b1);
        check("full_count", count, 4'd8);
        step(0, 1, 16'd1, 16'h99, 0);
        check("full_blocked_rem", got_rem, 1'b0);
        check("full_hold_count", count, 4'd8);
        step(0, 1, 16'd1, 16'h98, 1);
        check("full_deq_rem", got_rem, 1'b0);
        check("full_deq_count", count, 4'd7);
        check("full_deq_full", full, 1'b0);
        check_model();

        // Simultaneous enqueue and dequeue.
        step(1, 0, 0, 0, 0);
        step(0, 1, 16'd4, 16'h40, 0);
        step(0, 1, 16'd6, 16'h60, 0);
        step(0, 1, 16'd1, 16'h10, 1);
        check("simul_rem", got_rem, 1'b1);
        check("simul_head", rank_out, 16'd1);
        check("simul_count", count, 4'd2);
        step(0, 0, 0, 0, 1);
        check("simul_next", rank_out, 16'd6);
        check("simul_meta", meta_out, 16'h60);

        // Reset mid-operation with in_valid and deq high.
        step(0, 1, 16'd3, 16'h1, 0);
        step(0, 1, 16'd8, 16'h2, 0);
        step(1, 1, 16'd2, 16'h3, 1);
        check("rst_rem", got_rem, 1'b0);
        check("rst_count", count, 4'd0);
        check("rst_valid", valid_out, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_rank", rank_out, 16'd0);
        check("rst_meta", meta_out, 16'd0);
        step(0, 1, 16'd7, 16'h77, 0);
        check("post_rst_head", rank_out, 16'd7);
        check("post_rst_count", count, 4'd1);

        // Rank wrap ordering.
        step(1, 0, 0, 0, 0);
        step(0, 1, 16'hFFFE, 16'hE, 0);
        step(0, 1, 16'h0001, 16'h1, 0);
`ifdef RANK_SORT_WRAP_EN
        check("wrap_head", rank_out, 16'hFFFE);
`else
        check("wrap_head", rank_out, 16'h0001);
`endif

        // Randomized traffic against the queue model.
        step(1, 0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0,
                 16'($urandom_range(0, 7)), 16'(n), $urandom_range(0, 2) == 0);
            check_model();
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/rank_sort_buf.md
RANK_SORT_BUF -- requirements
Module: rank_sort_buf

Interface
REQ-001 SHALL have parameter RANK_WIDTH, default 16, meaning the rank field width.
REQ-002 SHALL have parameter META_WIDTH, default 16, meaning the metadata field width.
REQ-003 SHALL have parameter L2_DEPTH, default 3, meaning log2 of the entry count (DEPTH = 2^L2_DEPTH = 8).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1, the reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, upstream rank stage holds a rank/meta pair.
REQ-007 SHALL have port in_rank, input, RANK_WIDTH, upstream rank.
REQ-008 SHALL have port in_meta, input, META_WIDTH, upstream metadata.
REQ-009 SHALL have port in_remove, output, 1, pop strobe to the upstream rank stage (drives its remove input).
REQ-010 SHALL have port deq, input, 1, downstream request to remove the head entry.
REQ-011 SHALL have port valid_out, output, 1, head entry valid.
REQ-012 SHALL have port rank_out, output, RANK_WIDTH, head (minimum) rank.
REQ-013 SHALL have port meta_out, output, META_WIDTH, head metadata.
REQ-014 SHALL have port count, output, L2_DEPTH+1, number of stored entries.
REQ-015 SHALL have port full, output, 1, count == DEPTH.

Function
REQ-016 SHALL store up to DEPTH entries in a register array kept sorted ascending by rank, entry 0 = head.
REQ-017 SHALL assert in_remove combinationally when in_valid && !full; an enqueue occurs on every cycle in_remove is high.
REQ-018 SHALL insert an enqueued entry after all stored entries of equal rank (FIFO order among ties), shifting later entries up one slot, in a single cycle.
REQ-019 SHALL drive valid_out = (count != 0), rank_out/meta_out = entry 0, all registered; an entry enqueued into an empty buffer appears on outputs the next cycle.
REQ-020 SHALL, on deq && valid_out, remove entry 0 at the clock edge and shift all entries down one slot; deq while empty is ignored with no state change.
REQ-021 SHALL, on simultaneous enqueue and dequeue, remove the head presented that cycle and insert the new entry among the remaining entries; count unchanged.
REQ-022 SHALL block enqueue when full even if deq is asserted the same cycle (in_remove = 0 whenever full).
REQ-023 SHALL update count as +1 enqueue only, -1 dequeue only, unchanged for both or neither; count never exceeds DEPTH or drops below 0.
REQ-024 SHALL leave entries at index >= count don't-care, never observable on outputs.

Reset
REQ-025 SHALL, while rst is high at a clock edge, set count = 0, valid_out = 0, full = 0, rank_out = 0, meta_out = 0, overriding any enqueue or dequeue that cycle.
REQ-026 SHALL hold in_remove = 0 during any cycle rst is high.
REQ-027 SHALL discard all stored entries on reset mid-operation; first post-reset enqueue behaves as into empty buffer.

Configuration
REQ-028 SHALL honour macro RANK_SORT_WRAP_EN: when defined, rank a precedes b iff (a - b) mod 2^RANK_WIDTH has its MSB set (serial-number compare, tolerating rank counter wrap).
REQ-029 SHALL, when RANK_SORT_WRAP_EN is undefined, order ranks by plain unsigned comparison.

Verification
REQ-030 SHALL cover sorting: enqueue ranks 5,2,9,2(meta A,B,C,D) on empty buffer, then deq x4 -> outputs 2/B, 2/D, 5/A, 9/C, valid_out 0 after.
REQ-031 SHALL cover full: in_valid held, 8 enqueues -> full = 1, count = 8, in_remove = 0 on 9th cycle; deq+in_valid same cycle while full -> count 7, no enqueue.
REQ-032 SHALL cover simultaneous: buffer holds 4,6; enqueue rank 1 with deq same cycle -> next head 1, then 6, count stays 2.
REQ-033 SHALL cover reset mid-operation: 3 entries stored, rst one cycle with in_valid and deq high -> count 0, valid_out 0, in_remove 0 that cycle.
REQ-034 SHALL cover wrap with RANK_SORT_WRAP_EN defined: enqueue 0xFFFE then 0x0001 -> head 0xFFFE first; undefined -> head 0x0001 first.
REQ-035 SHALL cover empty deq: deq asserted with count 0 for 3 cycles -> no state change, valid_out stays 0.
